board_controller: RTL and testbench

BOARD_CONTROLLER -- requirements
Module: board_controller

---
 rtl/board_controller_pkg.sv | 17 +
 rtl/lfsr16.sv | 25 ++
 rtl/board_controller.sv | 141 ++++++++++++++
 tb/tb_board_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/board_controller_pkg.sv
// Shared types and constants for the lights-out style board controller.
package board_controller_pkg;

    typedef enum logic [1:0] {
        ST_SCRAMBLE = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_PLAY     = 2'd2,
        ST_WON      = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam int unsigned SCRAMBLE_LEN_DEFAULT = 32;
    localparam logic [9:0]  MOVE_MAX = 10'd1023;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; q[0] is the output bit used for scrambling.
module lfsr16
    import board_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/board_controller.sv
// Game controller: scrambles the board, then moves a cursor and toggles 3-cell groups until a win.
//   state    | meaning
//   SCRAMBLE | shift LFSR bits into the board for ScrambleLen cycles
//   SETTLE   | one cycle to let win_in reflect the scrambled board
//   PLAY     | cursor moves and toggles accepted
//   WON      | board frozen; toggle starts a new game
module board_controller
    import board_controller_pkg::*;
#(
    parameter int NumberOfBits = 31,
    parameter int ScrambleLen  = SCRAMBLE_LEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_toggle,
    input  logic                  win_in,
    output logic [NumberOfBits:0] ScreenValues,
    output logic [4:0]            cursor,
    output logic [9:0]            move_count,
    output logic                  playing
);

    localparam int CNT_W = $clog2(ScrambleLen + 1);
    localparam logic [CNT_W-1:0] SCR_LAST = CNT_W'(ScrambleLen - 1);

    state_e                  state_q, state_d;
    logic [NumberOfBits:0]   board_q, board_d;
    logic [4:0]              cursor_q, cursor_d;
    logic [9:0]              moves_q, moves_d;
    logic [CNT_W-1:0]        scr_cnt_q, scr_cnt_d;
    logic                    playing_q;
    logic [2:0]              btn_prev_q;

    logic [15:0]             lfsr;
    logic                    unused_lfsr;
    logic                    ev_toggle, ev_right, ev_left;
    logic [4:0]              cursor_inc, cursor_dec;
    logic [NumberOfBits:0]   flip_mask;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:1];

    // Priority toggle > right > left; lower events in the same cycle are dropped.
    assign ev_toggle = btn_toggle & ~btn_prev_q[2];
    assign ev_right  = btn_right  & ~btn_prev_q[1] & ~ev_toggle;
    assign ev_left   = btn_left   & ~btn_prev_q[0] & ~ev_toggle & ~ev_right;

    assign cursor_inc = cursor_q + 5'd1;
    assign cursor_dec = cursor_q - 5'd1;

    always_comb begin
        flip_mask             = '0;
        flip_mask[cursor_q]   = 1'b1;
        flip_mask[cursor_inc] = 1'b1;
        flip_mask[cursor_dec] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        cursor_d  = cursor_q;
        moves_d   = moves_q;
        scr_cnt_d = scr_cnt_q;

        case (state_q)
            ST_SCRAMBLE: begin
                board_d = {board_q[NumberOfBits-1:0], lfsr[0]};
                if (scr_cnt_q == SCR_LAST) begin
                    scr_cnt_d = '0;
                    state_d   = ST_SETTLE;
                end else begin
                    scr_cnt_d = scr_cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                scr_cnt_d = '0;
                state_d   = win_in ? ST_SCRAMBLE : ST_PLAY;
            end
            ST_PLAY: begin
                if (ev_toggle) begin
                    board_d = board_q ^ flip_mask;
                    if (moves_q != MOVE_MAX) begin
                        moves_d = moves_q + 10'd1;
                    end
                end else if (ev_right) begin
                    cursor_d = cursor_inc;
                end else if (ev_left) begin
                    cursor_d = cursor_dec;
                end
                if (win_in) begin
                    state_d = ST_WON;
                end
            end
            ST_WON: begin
                if (ev_toggle) begin
                    state_d   = ST_SCRAMBLE;
                    moves_d   = '0;
                    cursor_d  = '0;
                    scr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_SCRAMBLE;
                scr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SCRAMBLE;
            board_q    <= '0;
            cursor_q   <= '0;
            moves_q    <= '0;
            scr_cnt_q  <= '0;
            playing_q  <= 1'b0;
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            cursor_q   <= cursor_d;
            moves_q    <= moves_d;
            scr_cnt_q  <= scr_cnt_d;
            playing_q  <= (state_d == ST_PLAY);
            btn_prev_q <= {btn_toggle, btn_right, btn_left};
        end
    end

    assign ScreenValues = board_q;
    assign cursor       = cursor_q;
    assign move_count   = moves_q;
    assign playing      = playing_q;

endmodule

// File: tb/tb_board_controller.sv
// Directed self-checking bench for board_controller with a bench-side LFSR/board model.
module tb_board_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_left, btn_right, btn_toggle, win_in;
    logic [31:0] ScreenValues;
    logic [4:0]  cursor;
    logic [9:0]  move_count;
    logic        playing;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_lfsr;
    logic [31:0] exp_board;
    logic [31:0] golden;

    board_controller dut (
        .clk          (clk),
        .reset        (reset),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_toggle   (btn_toggle),
        .win_in       (win_in),
        .ScreenValues (ScreenValues),
        .cursor       (cursor),
        .move_count   (move_count),
        .playing      (playing)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; the model uses pre-edge LFSR state, as the DUT does.
    task automatic tick(input bit shift);
        @(posedge clk);
        #1;
        if (reset) begin
            m_lfsr    = 16'hACE1;
            exp_board = '0;
        end else begin
            if (shift) exp_board = {exp_board[30:0], m_lfsr[0]};
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic pulse(input int which);
        case (which)
            0: btn_left   = 1'b1;
            1: btn_right  = 1'b1;
            default: btn_toggle = 1'b1;
        endcase
        tick(1'b0);
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_toggle = 1'b0;
        tick(1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_toggle = 1'b0;
        win_in     = 1'b0;
        m_lfsr     = 16'hACE1;
        exp_board  = '0;

        tick(1'b0);
        tick(1'b0);
        chk("rst_board",   ScreenValues, 32'h0);
        chk("rst_cursor",  32'(cursor), 32'h0);
        chk("rst_moves",   32'(move_count), 32'h0);
        chk("rst_playing", 32'(playing), 32'h0);
        chk("rst_lfsr",    32'(dut.lfsr), 32'h0000ACE1);

        reset = 1'b0;
        repeat (32) tick(1'b1);
        golden = exp_board;
        chk("scramble_board",  ScreenValues, exp_board);
        chk("settle_playing",  32'(playing), 32'h0);
        tick(1'b0);
        chk("play_entered",    32'(playing), 32'h1);

        pulse(2);
        exp_board = golden ^ 32'h80000003;
        chk("toggle_c0_board", ScreenValues, exp_board);
        chk("toggle_c0_moves", 32'(move_count), 32'd1);

        pulse(0);
        chk("left_wrap",  32'(cursor), 32'd31);
        pulse(1);
        chk("right_wrap", 32'(cursor), 32'd0);
        btn_right = 1'b1;
        repeat (10) tick(1'b0);
        btn_right = 1'b0;
        tick(1'b0);
        chk("held_right", 32'(cursor), 32'd1);

        repeat (4) pulse(1);
        chk("cursor_to5", 32'(cursor), 32'd5);

        btn_toggle = 1'b1;
        btn_right  = 1'b1;
        tick(1'b0);
        btn_toggle = 1'b0;
        btn_right  = 1'b0;
        tick(1'b0);
        exp_board = exp_board ^ 32'h00000070;
        chk("prio_board",  ScreenValues, exp_board);
        chk("prio_cursor", 32'(cursor), 32'd5);
        chk("prio_moves",  32'(move_count), 32'd2);

        win_in     = 1'b1;
        btn_toggle = 1'b1;
        tick(1'b0);
        win_in     = 1'b0;
        btn_toggle = 1'b0;
        exp_board  = exp_board ^ 32'h00000070;
        chk("win_playing", 32'(playing), 32'h0);
        chk("win_board",   ScreenValues, exp_board);
        chk("win_moves",   32'(move_count), 32'd3);
        tick(1'b0);

        pulse(1);
        pulse(0);
        chk("won_cursor", 32'(cursor), 32'd5);
        chk("won_board",  ScreenValues, exp_board);
        chk("won_moves",  32'(move_count), 32'd3);

        btn_toggle = 1'b1;
        tick(1'b0);
        chk("newgame_moves",   32'(move_count), 32'd0);
        chk("newgame_cursor",  32'(cursor), 32'd0);
        chk("newgame_playing", 32'(playing), 32'h0);
        btn_toggle = 1'b0;
        repeat (32) tick(1'b1);
        chk("newgame_board",   ScreenValues, exp_board);
        chk("newgame_settle",  32'(playing), 32'h0);

        win_in = 1'b1;
        tick(1'b0);
        win_in = 1'b0;
        chk("rescramble_playing", 32'(playing), 32'h0);
        repeat (32) tick(1'b1);
        chk("rescramble_board",   ScreenValues, exp_board);
        tick(1'b0);
        chk("rescramble_play",    32'(playing), 32'h1);

        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        repeat (17) tick(1'b1);
        reset = 1'b1;
        tick(1'b0);
        chk("midrst_board",   ScreenValues, 32'h0);
        chk("midrst_cursor",  32'(cursor), 32'h0);
        chk("midrst_moves",   32'(move_count), 32'h0);
        chk("midrst_playing", 32'(playing), 32'h0);
        chk("midrst_lfsr",    32'(dut.lfsr), 32'h0000ACE1);
        reset = 1'b0;
        repeat (31) tick(1'b1);
        chk("restart_not_yet", 32'(playing), 32'h0);
        tick(1'b1);
        chk("restart_board",   ScreenValues, golden);
        tick(1'b0);
        chk("restart_play",    32'(playing), 32'h1);

        repeat (1023) begin
            pulse(2);
            exp_board = exp_board ^ 32'h80000003;
        end
        chk("sat_1023_moves", 32'(move_count), 32'd1023);
        chk("sat_1023_board", ScreenValues, exp_board);
        repeat (7) begin
            pulse(2);
            exp_board = exp_board ^ 32'h80000003;
        end
        chk("sat_1030_moves", 32'(move_count), 32'd1023);
        chk("sat_1030_board", ScreenValues, golden);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
